aes_core: RTL and testbench

Iterative AES block-cipher engine (FIPS-197) covering encryption, inverse-cipher decryption and on-the-fly key expansion for AES-128/192/256, selected by parameters. It processes one 128-bit block at a time, one round per clock. It sits below the AES demo top level, which drives plaintext/key, compares results against known-answer vectors and shows them on 7-segment displays.

---
 rtl/aes_pkg.sv | 132 +++++++++++++
 rtl/aes_key_expand.sv | 37 +++
 rtl/aes_core.sv | 105 ++++++++++
 tb/tb_aes_core.sv | 137 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES (FIPS-197) helpers: arithmetic S-boxes, GF(2^8) math, key-schedule words
// and whole-state round transforms. Byte i of a state lives at bits [127-8i -: 8].
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input int unsigned i);
        case (i)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            o[127-8*(4*c+0) -: 8] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
            o[127-8*(4*c+1) -: 8] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
            o[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
            o[127-8*(4*c+3) -: 8] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            o[127-8*(4*c+0) -: 8] = gf_mul(a[0], 8'h0e) ^ gf_mul(a[1], 8'h0b)
                                  ^ gf_mul(a[2], 8'h0d) ^ gf_mul(a[3], 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a[0], 8'h09) ^ gf_mul(a[1], 8'h0e)
                                  ^ gf_mul(a[2], 8'h0b) ^ gf_mul(a[3], 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a[0], 8'h0d) ^ gf_mul(a[1], 8'h09)
                                  ^ gf_mul(a[2], 8'h0e) ^ gf_mul(a[3], 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a[0], 8'h0b) ^ gf_mul(a[1], 8'h0d)
                                  ^ gf_mul(a[2], 8'h09) ^ gf_mul(a[3], 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES key expansion; round key r occupies schedule word slots 4r..4r+3,
// word 0 in the MSBs.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic [32*NK-1:0]      key_i,
    output logic [128*(NR+1)-1:0] schedule_o
);

    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned SW = 128 * (NR + 1);

    logic [31:0] w [NW];
    logic [31:0] temp;

    always_comb begin
        temp       = 32'h0;
        schedule_o = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (i < NK) begin
                w[i] = key_i[32*NK-1-32*i -: 32];
            end else begin
                temp = w[i-1];
                if (i % NK == 0)
                    temp = sub_word(rot_word(temp)) ^ {rcon(i / NK), 24'h0};
                else if (NK > 6 && i % NK == 4)
                    temp = sub_word(temp);
                w[i] = w[i-NK] ^ temp;
            end
            schedule_o[SW-1-32*i -: 32] = w[i];
        end
    end

endmodule

// File: rtl/aes_core.sv
// Iterative AES encrypt/decrypt engine: one round per clock, NR cycles per block,
// round keys taken from a combinational key schedule.
module aes_core
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 decrypt,
    input  logic [BLOCK_W-1:0]   data_in,
    input  logic [32*NK-1:0]     key,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned SW   = 128 * (NR + 1);
    localparam logic [3:0]  NR_L = 4'(NR);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t                fsm_q;
    logic [3:0]          cnt_q;
    logic                dec_q;
    logic [BLOCK_W-1:0]  state_q;
    logic [BLOCK_W-1:0]  data_out_q;
    logic                busy_q;
    logic                done_q;

    logic [SW-1:0]       sched;
    logic [3:0]          rk_idx;
    logic [BLOCK_W-1:0]  rk;
    logic [BLOCK_W-1:0]  rk_first;
    logic [BLOCK_W-1:0]  round_d;
    logic [BLOCK_W-1:0]  t;

    aes_key_expand #(.NK(NK), .NR(NR)) u_kexp (
        .key_i      (key),
        .schedule_o (sched)
    );

    // Decrypt walks the schedule backwards from rk NR-1 down to rk0
    always_comb begin
        rk_idx   = dec_q ? 4'(NR_L - cnt_q) : cnt_q;
        rk       = sched[SW-1-128*int'(rk_idx) -: 128];
        rk_first = decrypt ? sched[127:0] : sched[SW-1 -: 128];
    end

    always_comb begin
        t       = '0;
        round_d = '0;
        if (dec_q) begin
            t       = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;
            round_d = (cnt_q == NR_L) ? t : inv_mix_columns(t);
        end else begin
            t       = shift_rows(sub_bytes(state_q));
            round_d = ((cnt_q == NR_L) ? t : mix_columns(t)) ^ rk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            cnt_q      <= 4'd0;
            dec_q      <= 1'b0;
            state_q    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= data_in ^ rk_first;
                        dec_q   <= decrypt;
                        cnt_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= round_d;
                    if (cnt_q == NR_L) begin
                        data_out_q <= round_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        fsm_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_core.sv
// Directed known-answer bench for aes_core at AES-128/192/256.
module tb_aes_core;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K4  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K8  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] LAST_RK4 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   start_v = 3'b000;
    logic         dec = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] dout [3];
    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [1407:0] sched4;

    int checks = 0;
    int errors = 0;
    int cyc;
    int ndone;

    always #5 clk = ~clk;

    aes_core #(.NK(4), .NR(10)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .decrypt(dec), .data_in(din),
        .key(K4), .data_out(dout[0]), .busy(busy_v[0]), .done(done_v[0]));
    aes_core #(.NK(6), .NR(12)) u_dut6 (
        .clk(clk), .rst(rst), .start(start_v[1]), .decrypt(dec), .data_in(din),
        .key(K6), .data_out(dout[1]), .busy(busy_v[1]), .done(done_v[1]));
    aes_core #(.NK(8), .NR(14)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .decrypt(dec), .data_in(din),
        .key(K8), .data_out(dout[2]), .busy(busy_v[2]), .done(done_v[2]));

    aes_key_expand #(.NK(4), .NR(10)) u_kexp4 (.key_i(K4), .schedule_o(sched4));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic launch(input int idx, input logic d, input logic [127:0] data);
        dec          = d;
        din          = data;
        start_v      = 3'b000;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
    endtask

    // Counts cycles after the start edge until done; checks latency, busy and result
    task automatic wait_done(input int idx, input logic [127:0] exp, input string tag);
        int nr;
        nr  = 10 + 2 * idx;
        cyc = 0;
        check({tag, "_busy_rise"}, 128'(busy_v[idx]), 128'(1));
        while (!done_v[idx] && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(nr));
        check({tag, "_data"}, dout[idx], exp);
        check({tag, "_busy_fall"}, 128'(busy_v[idx]), 128'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 128'(busy_v), 128'(0));
        check("reset_done", 128'(done_v), 128'(0));
        check("reset_dout", dout[0] | dout[1] | dout[2], 128'h0);
        rst = 1'b0;
        @(negedge clk);

        check("sched4_last_rk", sched4[127:0], LAST_RK4);
        check("sched4_rk0", sched4[1407 -: 128], K4);

        launch(0, 1'b0, PT);  wait_done(0, CT4, "enc128");
        launch(1, 1'b0, PT);  wait_done(1, CT6, "enc192");
        launch(2, 1'b0, PT);  wait_done(2, CT8, "enc256");
        launch(0, 1'b1, CT4); wait_done(0, PT, "dec128");
        launch(1, 1'b1, CT6); wait_done(1, PT, "dec192");
        launch(2, 1'b1, CT8); wait_done(2, PT, "dec256");

        // Hammer start with a different block while busy: only one done, original result
        launch(0, 1'b0, PT);
        din   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        ndone = 0;
        cyc   = 0;
        for (int k = 0; k < 16; k++) begin
            start_v[0] = busy_v[0];
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                if (cyc == 0) cyc = k + 1;
            end
        end
        start_v[0] = 1'b0;
        check("ignore_start_ndone", 128'(ndone), 128'(1));
        check("ignore_start_latency", 128'(cyc), 128'(10));
        check("ignore_start_data", dout[0], CT4);

        // Back-to-back: second start issued in the done cycle
        launch(1, 1'b0, PT);  wait_done(1, CT6, "b2b_first");
        launch(1, 1'b1, CT6); wait_done(1, PT, "b2b_second");

        // Reset on the edge that would apply round 5
        launch(0, 1'b0, PT);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 128'(busy_v[0]), 128'(0));
        check("midrst_done", 128'(done_v[0]), 128'(0));
        check("midrst_dout", dout[0], 128'h0);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'(0));
        launch(0, 1'b0, PT);  wait_done(0, CT4, "post_rst_enc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
